pattern_gen_sequencer: RTL and testbench
========================================

// Module: pattern_gen_sequencer
// PURPOSE
//  Command sequencer for the LFSR/counter pattern generator behind the pipe-out endpoint.
//  - Decodes one-cycle trigger pulses from an okTriggerIn and owns the run state machine.
//  - Drives the generator's seed-load, step and mode controls.
//  - Counts words drained through the pipe-out and ends a piped block after a programmed length.
//  - Reports status through a wire-out and signals completion through an okTriggerOut.
// PARAMETERS
//  CNT_W        16             width of block length and word counter
//  SEED_DEFAULT 32'h0000_0001  seed substituted when host seed is all-zero (LFSR lock-up guard)
// PORTS
//  ti_clk      in   1      host interface clock; all logic on posedge
//  reset       in   1      synchronous, active-high
//  trig_in     in   16     okTriggerIn pulses, 1 cycle each
//  seed_lo     in   16     seed bits [15:0] (okWireIn)
//  seed_hi     in   16     seed bits [31:16] (okWireIn)
//  block_len   in   CNT_W  words per piped block; 0 = unbounded
//  pipe_read   in   1      okPipeOut ep_read strobe
//  gen_mode    out  1      0 = LFSR, 1 = counter
//  gen_load    out  1      1-cycle pulse: generator loads gen_seed
//  gen_seed    out  32     seed value to load
//  gen_step    out  1      generator advances one word this cycle
//  word_count  out  CNT_W  words delivered in current/last block
//  status      out  16     wire-out: [2:0] state, [3] mode, [4] underrun, [5] done, [15:8] reserved 0
//  trig_out    out  16     okTriggerOut pulses: [0] block done, [1] underrun; others 0
// BEHAVIOUR
//  Reset (sync): state=IDLE, gen_mode=0, gen_load=0, gen_seed=SEED_DEFAULT, gen_step=0,
//   word_count=0, status=0, trig_out=0, seed reference=0.
//  Trigger bits: [0] sel LFSR, [1] sel counter, [2] stop, [3] start continuous,
//   [4] start piped, [5] reseed; others ignored.
//  Same-cycle priority: stop > reseed > start piped > start continuous.
//   Mode select is independent; if [0] and [1] both set, [1] wins.
//  Mode select is honoured only in IDLE/DONE; ignored while running.
//  States: IDLE, LOAD, RUN_CONT, RUN_PIPED, DONE.
//   IDLE/DONE + start_x -> LOAD. gen_load=1 for exactly one cycle.
//    Then go to RUN_CONT or RUN_PIPED; word_count cleared on entering LOAD.
//   Any state + stop -> IDLE next cycle; gen_step=0 from that edge; word_count held.
//   Any state + reseed -> LOAD, then return to the prior run state (IDLE/DONE return to IDLE).
//   Start while already running is ignored.
//   RUN_CONT: gen_step=1 every cycle.
//    If {seed_hi,seed_lo} differs from the registered reference, pulse gen_load (no step
//    that cycle) and update the reference.
//   RUN_PIPED: gen_step = pipe_read (combinational, same cycle); word_count += 1 per read.
//    When block_len!=0 and a read brings word_count to block_len: -> DONE next cycle.
//    trig_out[0] pulses 1 cycle; status[5]=1.
//    Reads in DONE/IDLE/LOAD: no step, trig_out[1] pulses, status[4] sticky until next start.
//  gen_seed = {seed_hi,seed_lo}, registered at LOAD; zero is replaced by SEED_DEFAULT.
//  word_count saturates at all-ones when block_len=0; no wrap.
//  status and trig_out are registered: 1-cycle latency after the event.
//  Trigger -> first gen_step latency: 2 cycles (LOAD + run).
// STRUCTURE
//  Shared package: state encoding (IDLE=0, LOAD=1, RUN_CONT=2, RUN_PIPED=3, DONE=4),
//   trigger bit indices, status bit indices, SEED_DEFAULT.
//  One sub-module, seq_block_counter: clear/increment/saturate/terminal-count compare.
//   The FSM stays in the top file.
// TESTING
//  1. Reset, trig[0], seed=0x0001_ACE1, trig[3]:
//     gen_load one cycle, then gen_step=1 continuous; status[2:0]=2.
//  2. trig[1], block_len=4, trig[4], 4 pipe_read pulses:
//     4 gen_step, word_count=4, trig_out[0] pulse, status[2:0]=4, status[5]=1.
//  3. In RUN_PIPED, pipe_read and trig[2] on the same cycle:
//     step counted, state IDLE next cycle, no done pulse.
//  4. Seed 0 + start: gen_seed=0x0000_0001.
//     In RUN_CONT, change seed_lo to 0x1234: exactly one gen_load, step suppressed that cycle.
//  5. pipe_read in IDLE: trig_out[1] pulse, status[4]=1, gen_step=0.
//     Next trig[4] clears status[4].
//  6. Reset asserted mid RUN_PIPED at word_count=2:
//     all outputs at reset values next cycle; trig[2|5] with trig[4] -> stop wins.

Source files
------------

// File: rtl/pattern_gen_sequencer_pkg.sv
// Shared definitions for the pattern generator command sequencer:
// state encoding, okTriggerIn/okTriggerOut bit indices, status bit
// indices, the lock-up-safe default seed and a seed substitution helper.
package pattern_gen_sequencer_pkg;

  localparam int unsigned STATE_W = 3;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_LOAD      = 3'd1;
  localparam state_t ST_RUN_CONT  = 3'd2;
  localparam state_t ST_RUN_PIPED = 3'd3;
  localparam state_t ST_DONE      = 3'd4;

  localparam int unsigned TRIG_W = 16;

  // okTriggerIn bit positions
  localparam int unsigned TRIG_SEL_LFSR    = 0;
  localparam int unsigned TRIG_SEL_COUNTER = 1;
  localparam int unsigned TRIG_STOP        = 2;
  localparam int unsigned TRIG_START_CONT  = 3;
  localparam int unsigned TRIG_START_PIPED = 4;
  localparam int unsigned TRIG_RESEED      = 5;

  // okTriggerOut bit positions
  localparam int unsigned TOUT_DONE     = 0;
  localparam int unsigned TOUT_UNDERRUN = 1;

  // status wire-out bit positions; state occupies [STATE_W-1:0]
  localparam int unsigned STAT_W        = 16;
  localparam int unsigned STAT_MODE     = 3;
  localparam int unsigned STAT_UNDERRUN = 4;
  localparam int unsigned STAT_DONE     = 5;

  localparam int unsigned SEED_W = 32;

  // An all-zero LFSR seed never leaves zero, so it is replaced by this value.
  localparam logic [SEED_W-1:0] SEED_DEFAULT_VAL = 32'h0000_0001;

  // Returns the seed the generator should load for a host-supplied value.
  function automatic logic [SEED_W-1:0] seed_fix(input logic [SEED_W-1:0] seed,
                                                  input logic [SEED_W-1:0] dflt);
    return (seed == '0) ? dflt : seed;
  endfunction

  // True when trigger bit idx is set in a trigger word.
  function automatic logic trig_hit(input logic [TRIG_W-1:0] trig,
                                    input int unsigned       idx);
    return |(trig & (TRIG_W'(1) << idx));
  endfunction

endpackage

// File: rtl/pattern_gen_sequencer_seq_block_counter.sv
// Word counter for piped blocks.
// Ports:
//   ti_clk, reset : clock, synchronous active-high reset
//   clr           : clear count (wins over inc)
//   inc           : count one word this cycle
//   limit         : terminal count; 0 means unbounded
//   count         : registered word count, saturates at all-ones
//   tc_c          : combinational, this increment reaches a non-zero limit
module pattern_gen_sequencer_seq_block_counter #(
  parameter int unsigned W = 16
) (
  input  logic         ti_clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         tc_c
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic [W-1:0] count_inc;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    count_d   = count_q;
    count_inc = count_q + W'(1);
    tc_c      = inc && (limit != '0) && (count_inc == limit);
    if (clr) begin
      count_d = '0;
    end else if (inc && !(&count_q)) begin
      count_d = count_inc;
    end
  end

  always_ff @(posedge ti_clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pattern_gen_sequencer.sv
// Command sequencer for the LFSR/counter pattern generator behind a pipe-out.
// Ports:
//   ti_clk, reset        : host interface clock, synchronous active-high reset
//   trig_in              : okTriggerIn one-cycle command pulses
//   seed_lo, seed_hi     : host seed halves (okWireIn)
//   block_len            : words per piped block, 0 = unbounded
//   pipe_read            : okPipeOut ep_read strobe
//   gen_mode             : 0 = LFSR, 1 = counter
//   gen_load / gen_seed  : one-cycle load pulse and the seed to load
//   gen_step             : generator advances this cycle (combinational)
//   word_count           : words delivered in current/last block
//   status               : wire-out {reserved, done, underrun, mode, state}
//   trig_out             : okTriggerOut pulses, [0] block done, [1] underrun
module pattern_gen_sequencer
  import pattern_gen_sequencer_pkg::*;
#(
  parameter int unsigned       CNT_W        = 16,
  parameter logic [SEED_W-1:0] SEED_DEFAULT = SEED_DEFAULT_VAL
) (
  input  logic              ti_clk,
  input  logic              reset,
  input  logic [15:0]       trig_in,
  input  logic [15:0]       seed_lo,
  input  logic [15:0]       seed_hi,
  input  logic [CNT_W-1:0]  block_len,
  input  logic              pipe_read,
  output logic              gen_mode,
  output logic              gen_load,
  output logic [31:0]       gen_seed,
  output logic              gen_step,
  output logic [CNT_W-1:0]  word_count,
  output logic [15:0]       status,
  output logic [15:0]       trig_out
);

  state_t              state_q, state_d;
  state_t              ret_q, ret_d;
  logic                mode_q, mode_d;
  logic                gen_load_q, gen_load_d;
  logic [SEED_W-1:0]   gen_seed_q, gen_seed_d;
  logic [SEED_W-1:0]   ref_q, ref_d;
  logic                underrun_q, underrun_d;
  logic                done_q, done_d;
  logic [STAT_W-1:0]   status_q, status_d;
  logic [TRIG_W-1:0]   trig_out_q, trig_out_d;

  logic [SEED_W-1:0]   seed_in;
  logic                t_sel_lfsr, t_sel_cnt, t_stop, t_cont, t_piped, t_reseed;
  logic                idle_like;
  logic                cnt_clr, cnt_inc, cnt_tc_c;

  pattern_gen_sequencer_seq_block_counter #(
    .W (CNT_W)
  ) u_block_counter (
    .ti_clk (ti_clk),
    .reset  (reset),
    .clr    (cnt_clr),
    .inc    (cnt_inc),
    .limit  (block_len),
    .count  (word_count),
    .tc_c   (cnt_tc_c)
  );

  // Next-state, generator controls and status/trigger-out computation.
  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    mode_d     = mode_q;
    gen_load_d = 1'b0;
    gen_seed_d = gen_seed_q;
    ref_d      = ref_q;
    underrun_d = underrun_q;
    done_d     = done_q;
    trig_out_d = '0;
    status_d   = '0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    gen_step   = 1'b0;

    seed_in    = {seed_hi, seed_lo};
    t_sel_lfsr = trig_hit(trig_in, TRIG_SEL_LFSR);
    t_sel_cnt  = trig_hit(trig_in, TRIG_SEL_COUNTER);
    t_stop     = trig_hit(trig_in, TRIG_STOP);
    t_cont     = trig_hit(trig_in, TRIG_START_CONT);
    t_piped    = trig_hit(trig_in, TRIG_START_PIPED);
    t_reseed   = trig_hit(trig_in, TRIG_RESEED);
    idle_like  = (state_q == ST_IDLE) || (state_q == ST_DONE);

    // Mode only changes while the generator is parked; counter wins a tie.
    if (idle_like) begin
      if (t_sel_cnt) begin
        mode_d = 1'b1;
      end else if (t_sel_lfsr) begin
        mode_d = 1'b0;
      end
    end

    // Step generation; a reload pulse in RUN_CONT suppresses that cycle's step.
    case (state_q)
      ST_RUN_CONT:  gen_step = !gen_load_q;
      ST_RUN_PIPED: gen_step = pipe_read;
      default:      gen_step = 1'b0;
    endcase
    cnt_inc = (state_q == ST_RUN_PIPED) && pipe_read;

    // Reads with nothing being produced are an underrun.
    if (pipe_read && (idle_like || (state_q == ST_LOAD))) begin
      underrun_d                = 1'b1;
      trig_out_d[TOUT_UNDERRUN] = 1'b1;
    end

    if (t_stop) begin
      state_d = ST_IDLE;
    end else if (t_reseed) begin
      state_d    = ST_LOAD;
      gen_load_d = 1'b1;
      gen_seed_d = seed_fix(seed_in, SEED_DEFAULT);
      ref_d      = seed_in;
      cnt_clr    = 1'b1;
      // Remember where to resume; a reseed during LOAD keeps the pending target.
      case (state_q)
        ST_RUN_CONT, ST_RUN_PIPED: ret_d = state_q;
        ST_LOAD:                   ret_d = ret_q;
        default:                   ret_d = ST_IDLE;
      endcase
    end else if (idle_like && (t_piped || t_cont)) begin
      state_d    = ST_LOAD;
      ret_d      = t_piped ? ST_RUN_PIPED : ST_RUN_CONT;
      gen_load_d = 1'b1;
      gen_seed_d = seed_fix(seed_in, SEED_DEFAULT);
      ref_d      = seed_in;
      cnt_clr    = 1'b1;
      underrun_d = 1'b0;
      done_d     = 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          state_d = ret_q;
        end
        ST_RUN_CONT: begin
          // Host rewrote the seed wires: reload on the next cycle.
          if (seed_in != ref_q) begin
            gen_load_d = 1'b1;
            gen_seed_d = seed_fix(seed_in, SEED_DEFAULT);
            ref_d      = seed_in;
          end
        end
        ST_RUN_PIPED: begin
          if (cnt_tc_c) begin
            state_d               = ST_DONE;
            done_d                = 1'b1;
            trig_out_d[TOUT_DONE] = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end

    status_d[STATE_W-1:0]  = state_d;
    status_d[STAT_MODE]     = mode_d;
    status_d[STAT_UNDERRUN] = underrun_d;
    status_d[STAT_DONE]     = done_d;
  end

  // State and registered outputs.
  always_ff @(posedge ti_clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ret_q      <= ST_IDLE;
      mode_q     <= 1'b0;
      gen_load_q <= 1'b0;
      gen_seed_q <= SEED_DEFAULT;
      ref_q      <= '0;
      underrun_q <= 1'b0;
      done_q     <= 1'b0;
      status_q   <= '0;
      trig_out_q <= '0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      mode_q     <= mode_d;
      gen_load_q <= gen_load_d;
      gen_seed_q <= gen_seed_d;
      ref_q      <= ref_d;
      underrun_q <= underrun_d;
      done_q     <= done_d;
      status_q   <= status_d;
      trig_out_q <= trig_out_d;
    end
  end

  assign gen_mode = mode_q;
  assign gen_load = gen_load_q;
  assign gen_seed = gen_seed_q;
  assign status   = status_q;
  assign trig_out = trig_out_q;

endmodule

// File: tb/tb_pattern_gen_sequencer.sv
// Directed bench for pattern_gen_sequencer: a per-cycle vector table plus
// hand-written sequences for seed reload and reset/priority corner cases.
module tb_pattern_gen_sequencer;

  logic        ti_clk;
  logic        reset;
  logic [15:0] trig_in;
  logic [15:0] seed_lo;
  logic [15:0] seed_hi;
  logic [15:0] block_len;
  logic        pipe_read;
  logic        gen_mode;
  logic        gen_load;
  logic [31:0] gen_seed;
  logic        gen_step;
  logic [15:0] word_count;
  logic [15:0] status;
  logic [15:0] trig_out;

  int n_checks;
  int n_fail;

  pattern_gen_sequencer dut (
    .ti_clk     (ti_clk),
    .reset      (reset),
    .trig_in    (trig_in),
    .seed_lo    (seed_lo),
    .seed_hi    (seed_hi),
    .block_len  (block_len),
    .pipe_read  (pipe_read),
    .gen_mode   (gen_mode),
    .gen_load   (gen_load),
    .gen_seed   (gen_seed),
    .gen_step   (gen_step),
    .word_count (word_count),
    .status     (status),
    .trig_out   (trig_out)
  );

  initial ti_clk = 1'b0;
  always #5 ti_clk = ~ti_clk;

  typedef struct {
    logic [15:0] trig;
    logic        rd;
    logic        e_load;
    logic        e_step;
    logic        e_mode;
    logic [15:0] e_wc;
    logic [15:0] e_st;
    logic [15:0] e_to;
    logic [31:0] e_seed;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [15:0] trig, logic rd, logic ld, logic st,
                              logic md, logic [15:0] wc, logic [15:0] stat,
                              logic [15:0] to, logic [31:0] sd);
    vec_t v;
    v.trig = trig; v.rd = rd; v.e_load = ld; v.e_step = st; v.e_mode = md;
    v.e_wc = wc; v.e_st = stat; v.e_to = to; v.e_seed = sd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic next_cycle();
    @(posedge ti_clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1; trig_in = '0; pipe_read = 1'b0;
    repeat (cycles) next_cycle();
    reset = 1'b0;
  endtask

  localparam logic [31:0] S = 32'h0001_ACE1;

  initial begin
    int loads;
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1; trig_in = '0; seed_lo = '0; seed_hi = '0; block_len = '0; pipe_read = 1'b0;

    //            trig    rd  ld st md wc     status   tout     seed
    vecs.push_back(mk(16'h0000, 0, 0, 0, 0, 16'd0, 16'h0000, 16'h0, 32'h1));
    vecs.push_back(mk(16'h0001, 0, 0, 0, 0, 16'd0, 16'h0000, 16'h0, 32'h1));
    vecs.push_back(mk(16'h0008, 0, 0, 0, 0, 16'd0, 16'h0000, 16'h0, 32'h1));
    vecs.push_back(mk(16'h0000, 0, 1, 0, 0, 16'd0, 16'h0001, 16'h0, S));
    vecs.push_back(mk(16'h0000, 0, 0, 1, 0, 16'd0, 16'h0002, 16'h0, S));
    vecs.push_back(mk(16'h0000, 0, 0, 1, 0, 16'd0, 16'h0002, 16'h0, S));
    vecs.push_back(mk(16'h0002, 0, 0, 1, 0, 16'd0, 16'h0002, 16'h0, S));
    vecs.push_back(mk(16'h0004, 0, 0, 1, 0, 16'd0, 16'h0002, 16'h0, S));
    vecs.push_back(mk(16'h0002, 0, 0, 0, 0, 16'd0, 16'h0000, 16'h0, S));
    vecs.push_back(mk(16'h0010, 0, 0, 0, 1, 16'd0, 16'h0008, 16'h0, S));
    vecs.push_back(mk(16'h0000, 0, 1, 0, 1, 16'd0, 16'h0009, 16'h0, S));
    vecs.push_back(mk(16'h0000, 1, 0, 1, 1, 16'd0, 16'h000B, 16'h0, S));
    vecs.push_back(mk(16'h0000, 0, 0, 0, 1, 16'd1, 16'h000B, 16'h0, S));
    vecs.push_back(mk(16'h0000, 1, 0, 1, 1, 16'd1, 16'h000B, 16'h0, S));
    vecs.push_back(mk(16'h0000, 1, 0, 1, 1, 16'd2, 16'h000B, 16'h0, S));
    vecs.push_back(mk(16'h0000, 1, 0, 1, 1, 16'd3, 16'h000B, 16'h0, S));
    vecs.push_back(mk(16'h0000, 0, 0, 0, 1, 16'd4, 16'h002C, 16'h1, S));
    vecs.push_back(mk(16'h0000, 1, 0, 0, 1, 16'd4, 16'h002C, 16'h0, S));
    vecs.push_back(mk(16'h0000, 0, 0, 0, 1, 16'd4, 16'h003C, 16'h2, S));
    vecs.push_back(mk(16'h0010, 0, 0, 0, 1, 16'd4, 16'h003C, 16'h0, S));
    vecs.push_back(mk(16'h0000, 0, 1, 0, 1, 16'd0, 16'h0009, 16'h0, S));
    vecs.push_back(mk(16'h0004, 1, 0, 1, 1, 16'd0, 16'h000B, 16'h0, S));
    vecs.push_back(mk(16'h0000, 0, 0, 0, 1, 16'd1, 16'h0008, 16'h0, S));
    vecs.push_back(mk(16'h0000, 1, 0, 0, 1, 16'd1, 16'h0008, 16'h0, S));
    vecs.push_back(mk(16'h0000, 0, 0, 0, 1, 16'd1, 16'h0018, 16'h2, S));
    vecs.push_back(mk(16'h0010, 0, 0, 0, 1, 16'd1, 16'h0018, 16'h0, S));
    vecs.push_back(mk(16'h0000, 0, 1, 0, 1, 16'd0, 16'h0009, 16'h0, S));
    vecs.push_back(mk(16'h0020, 0, 0, 0, 1, 16'd0, 16'h000B, 16'h0, S));
    vecs.push_back(mk(16'h0000, 0, 1, 0, 1, 16'd0, 16'h0009, 16'h0, S));
    vecs.push_back(mk(16'h0000, 1, 0, 1, 1, 16'd0, 16'h000B, 16'h0, S));

    // Table: continuous run, piped block to DONE, underruns, stop+read, reseed.
    do_reset(2);
    seed_hi = S[31:16]; seed_lo = S[15:0]; block_len = 16'd4;
    foreach (vecs[i]) begin
      trig_in   = vecs[i].trig;
      pipe_read = vecs[i].rd;
      @(negedge ti_clk);
      chk($sformatf("row%0d gen_load", i),   32'(gen_load),   32'(vecs[i].e_load));
      chk($sformatf("row%0d gen_step", i),   32'(gen_step),   32'(vecs[i].e_step));
      chk($sformatf("row%0d gen_mode", i),   32'(gen_mode),   32'(vecs[i].e_mode));
      chk($sformatf("row%0d word_count", i), 32'(word_count), 32'(vecs[i].e_wc));
      chk($sformatf("row%0d status", i),     32'(status),     32'(vecs[i].e_st));
      chk($sformatf("row%0d trig_out", i),   32'(trig_out),   32'(vecs[i].e_to));
      chk($sformatf("row%0d gen_seed", i),   gen_seed,        vecs[i].e_seed);
      next_cycle();
    end

    // Zero seed is substituted; a seed change in RUN_CONT reloads exactly once.
    do_reset(2);
    seed_hi = 16'h0000; seed_lo = 16'h0000;
    trig_in = 16'h0009;
    @(negedge ti_clk);
    chk("s4 idle status", 32'(status), 32'h0);
    next_cycle();
    trig_in = 16'h0000;
    @(negedge ti_clk);
    chk("s4 load pulse", 32'(gen_load), 32'h1);
    chk("s4 zero seed fix", gen_seed, 32'h0000_0001);
    next_cycle();
    @(negedge ti_clk);
    chk("s4 run load", 32'(gen_load), 32'h0);
    chk("s4 run step", 32'(gen_step), 32'h1);
    chk("s4 run status", 32'(status), 32'h2);
    next_cycle();
    seed_lo = 16'h1234;
    @(negedge ti_clk);
    chk("s4 change cycle step", 32'(gen_step), 32'h1);
    loads = 0;
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      @(negedge ti_clk);
      if (gen_load) begin
        loads++;
        chk("s4 reload seed", gen_seed, 32'h0000_1234);
      end
      chk($sformatf("s4 step vs load c%0d", k), 32'(gen_step), 32'(!gen_load));
    end
    chk("s4 reload count", 32'(loads), 32'd1);
    next_cycle();

    // Reset mid RUN_PIPED, then stop beats reseed and start piped.
    do_reset(1);
    seed_hi = S[31:16]; seed_lo = S[15:0]; block_len = 16'd8;
    trig_in = 16'h0010;
    next_cycle();
    trig_in = 16'h0000;
    next_cycle();
    pipe_read = 1'b1;
    next_cycle();
    next_cycle();
    pipe_read = 1'b0;
    @(negedge ti_clk);
    chk("s6 wc before reset", 32'(word_count), 32'd2);
    chk("s6 status before reset", 32'(status), 32'h0003);
    next_cycle();
    reset = 1'b1; pipe_read = 1'b1;
    next_cycle();
    @(negedge ti_clk);
    chk("s6 rst gen_load", 32'(gen_load), 32'h0);
    chk("s6 rst gen_step", 32'(gen_step), 32'h0);
    chk("s6 rst gen_mode", 32'(gen_mode), 32'h0);
    chk("s6 rst word_count", 32'(word_count), 32'h0);
    chk("s6 rst status", 32'(status), 32'h0);
    chk("s6 rst trig_out", 32'(trig_out), 32'h0);
    chk("s6 rst gen_seed", gen_seed, 32'h1);
    next_cycle();
    reset = 1'b0; pipe_read = 1'b0; trig_in = 16'h0034;
    @(negedge ti_clk);
    chk("s6 prio same cycle status", 32'(status), 32'h0);
    next_cycle();
    trig_in = 16'h0000;
    @(negedge ti_clk);
    chk("s6 prio gen_load", 32'(gen_load), 32'h0);
    chk("s6 prio status", 32'(status), 32'h0);
    chk("s6 prio trig_out", 32'(trig_out), 32'h0);
    next_cycle();
    @(negedge ti_clk);
    chk("s6 prio gen_step", 32'(gen_step), 32'h0);
    chk("s6 prio status later", 32'(status), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
